// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the off-chip memory port arbiter and its cache clients.
package mem_port_arbiter_pkg;

  localparam int unsigned LINE_W_DEF = 256;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned TMO_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Two-requester selector: grant when either requests; on collision the preferred side (ptr) wins.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic ptr,
  output logic grant,
  output logic owner
);

  always_comb begin
    grant = i_req | d_req;
    owner = OWN_I;
    if (i_req && d_req) begin
      owner = ptr;
    end else if (d_req) begin
      owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port off-chip memory arbiter between I-cache and D-cache miss paths, with watchdog.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed D-over-I priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LINE_W = LINE_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned TMO_W  = TMO_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ack_o,
  input  logic              d_req_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [LINE_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [LINE_W-1:0] rdata_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              mem_stall_o,
  output logic              tmo_err_o
);

  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  arb_state_t       state;
  owner_t           owner_q;
  logic [TMO_W-1:0] wd_cnt;
  logic             pick_grant;
  logic             pick_owner;
  logic             pick_ptr;

`ifdef MEM_ARB_RR_EN
  owner_t rr_ptr;
  assign pick_ptr = rr_ptr;
`else
  assign pick_ptr = OWN_D;
`endif

  mem_arb_pick u_pick (
    .i_req (i_req_i),
    .d_req (d_req_i),
    .ptr   (pick_ptr),
    .grant (pick_grant),
    .owner (pick_owner)
  );

  // Freeze drops in DONE so the pipeline can consume the returned line that cycle.
  assign mem_stall_o = (i_req_i | d_req_i) & (state != DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      owner_q      <= OWN_I;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      rdata_o      <= '0;
      i_ack_o      <= 1'b0;
      d_ack_o      <= 1'b0;
      wd_cnt       <= '0;
      tmo_err_o    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_ptr       <= OWN_I;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_grant) begin
            owner_q      <= owner_t'(pick_owner);
            mem_enable_o <= 1'b1;
            wd_cnt       <= '0;
            state        <= BUSY;
            if (pick_owner == OWN_D) begin
              mem_write_o <= d_write_i;
              mem_addr_o  <= d_addr_i;
              mem_data_o  <= d_wdata_i;
            end else begin
              mem_write_o <= 1'b0;
              mem_addr_o  <= i_addr_i;
              mem_data_o  <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            rdata_o      <= mem_data_i;
            mem_enable_o <= 1'b0;
            i_ack_o      <= (owner_q == OWN_I);
            d_ack_o      <= (owner_q == OWN_D);
            state        <= DONE;
          end else if (wd_cnt != '1) begin
            // Saturating count; the error flag sets on the same edge the count reaches all-ones.
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == TMO_LAST) begin
              tmo_err_o <= 1'b1;
            end
          end
        end
        DONE: begin
          i_ack_o <= 1'b0;
          d_ack_o <= 1'b0;
          state   <= IDLE;
`ifdef MEM_ARB_RR_EN
          rr_ptr  <= (owner_q == OWN_I) ? OWN_D : OWN_I;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model compared every cycle plus directed literal checks.
module tb_mem_port_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          i_req_i = 1'b0;
  logic [AW-1:0] i_addr_i = '0;
  logic          i_ack_o;
  logic          d_req_i = 1'b0;
  logic          d_write_i = 1'b0;
  logic [AW-1:0] d_addr_i = '0;
  logic [LW-1:0] d_wdata_i = '0;
  logic          d_ack_o;
  logic [LW-1:0] rdata_o;
  logic          mem_enable_o;
  logic          mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_data_o;
  logic          mem_ack_i = 1'b0;
  logic [LW-1:0] mem_data_i = '0;
  logic          mem_stall_o;
  logic          tmo_err_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LINE_W(LW), .ADDR_W(AW), .TMO_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_ack_o(i_ack_o),
    .d_req_i(d_req_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_ack_o(d_ack_o), .rdata_o(rdata_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .mem_stall_o(mem_stall_o), .tmo_err_o(tmo_err_o)
  );

  // Model: phase 0 = waiting for a request, 1 = memory access open, 2 = returning to requester.
  int            m_phase;
  int            m_wait;
  logic          m_own_d;
  logic [AW-1:0] m_addr;
  logic          m_write;
  logic [LW-1:0] m_wdata;
  logic [LW-1:0] m_rdata;
  logic          m_tmo;
  logic          m_fresh;

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      m_phase <= 0; m_wait <= 0; m_own_d <= 1'b0; m_addr <= '0; m_write <= 1'b0;
      m_wdata <= '0; m_rdata <= '0; m_tmo <= 1'b0; m_fresh <= 1'b1;
    end else begin
      case (m_phase)
        0: if (i_req_i || d_req_i) begin
             m_own_d <= d_req_i;
             m_addr  <= d_req_i ? d_addr_i : i_addr_i;
             m_write <= d_req_i && d_write_i;
             m_wdata <= d_wdata_i;
             m_wait  <= 0;
             m_fresh <= 1'b0;
             m_phase <= 1;
           end
        1: if (mem_ack_i) begin
             m_rdata <= mem_data_i;
             m_phase <= 2;
           end else begin
             m_wait <= m_wait + 1;
             if (m_wait + 1 >= 255) m_tmo <= 1'b1;
           end
        default: m_phase <= 0;
      endcase
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin n_bad++; $display("FAIL %s: got %b, expected %b", nm, act, exp); end
  endtask

  task automatic chk_a(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin n_bad++; $display("FAIL %s: got %h, expected %h", nm, act, exp); end
  endtask

  task automatic chk_w(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin n_bad++; $display("FAIL %s: got %h, expected %h", nm, act, exp); end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin n_bad++; $display("FAIL %s: got %0d, expected %0d", nm, act, exp); end
  endtask

  task automatic compare_all();
    chk_b("mem_enable", mem_enable_o, m_phase == 1);
    chk_b("i_ack", i_ack_o, (m_phase == 2) && !m_own_d);
    chk_b("d_ack", d_ack_o, (m_phase == 2) && m_own_d);
    chk_b("mem_stall", mem_stall_o, (i_req_i || d_req_i) && (m_phase != 2));
    chk_b("tmo_err", tmo_err_o, m_tmo);
    if (m_phase == 1) begin
      chk_a("mem_addr", mem_addr_o, m_addr);
      chk_b("mem_write", mem_write_o, m_write);
      if (m_write) chk_w("mem_data", mem_data_o, m_wdata);
    end
    if (m_phase == 2) chk_w("rdata", rdata_o, m_rdata);
    if (m_fresh) begin
      chk_a("rst_mem_addr", mem_addr_o, '0);
      chk_b("rst_mem_write", mem_write_o, 1'b0);
      chk_w("rst_mem_data", mem_data_o, '0);
      chk_w("rst_rdata", rdata_o, '0);
    end
  endtask

  // Stimulus state: memory latency (0 = never acks), requester auto-drop, spurious ack.
  int   mem_lat = 0;
  int   busy_k = 0;
  logic spurious = 1'b0;
  logic last_i_ack = 1'b0;
  logic last_d_ack = 1'b0;

  task automatic cycle();
    @(posedge clk);
    #2;
    if (last_i_ack) i_req_i = 1'b0;
    if (last_d_ack) d_req_i = 1'b0;
    if (mem_enable_o) busy_k++; else busy_k = 0;
    mem_ack_i = spurious || (mem_enable_o && (mem_lat != 0) && (busy_k == mem_lat));
    spurious = 1'b0;
    @(negedge clk);
    last_i_ack = i_ack_o;
    last_d_ack = d_ack_o;
    compare_all();
  endtask

  logic [LW-1:0] pat_a5;
  logic [LW-1:0] pat_3c;
  logic [LW-1:0] pat_5a;
  logic [LW-1:0] got_w;
  logic [7:0]    en_v, ia_v, da_v;
  int            en_cnt, ia_cnt, da_cnt, st_cnt, ack_at, dack_at;
  logic          got_wr;

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_3c = {32{8'h3C}};
    pat_5a = {32{8'h5A}};

    #1 rst_i = 1'b1;
    cycle(); cycle();
    chk_b("reset_enable", mem_enable_o, 1'b0);
    chk_b("reset_i_ack", i_ack_o, 1'b0);
    chk_b("reset_d_ack", d_ack_o, 1'b0);
    chk_b("reset_tmo", tmo_err_o, 1'b0);
    chk_w("reset_rdata", rdata_o, '0);
    rst_i = 1'b0;
    cycle();

    // I-cache fill, 4-cycle memory
    mem_lat = 4; mem_data_i = pat_a5; i_addr_i = 32'h100; i_req_i = 1'b1;
    en_cnt = 0; ia_cnt = 0; da_cnt = 0; st_cnt = 0; got_w = '0;
    for (int j = 0; j < 8; j++) begin
      cycle();
      if (j == 0) chk_b("i_req_to_enable_1cyc", mem_enable_o, 1'b1);
      if (mem_enable_o) begin en_cnt++; chk_a("i_fill_addr", mem_addr_o, 32'h100); end
      if (i_ack_o) begin ia_cnt++; got_w = rdata_o; end
      if (d_ack_o) da_cnt++;
      if (mem_stall_o) st_cnt++;
    end
    chk_i("i_fill_enable_cycles", en_cnt, 4);
    chk_i("i_fill_ack_pulses", ia_cnt, 1);
    chk_i("i_fill_d_ack_pulses", da_cnt, 0);
    chk_i("i_fill_stall_cycles", st_cnt, 4);
    chk_w("i_fill_rdata", got_w, pat_a5);

    // D-cache write-back, 2-cycle memory
    mem_lat = 2; mem_data_i = pat_5a; d_addr_i = 32'h200; d_wdata_i = pat_3c;
    d_write_i = 1'b1; d_req_i = 1'b1;
    ack_at = -1; dack_at = -1; da_cnt = 0; got_wr = 1'b0; got_w = '0;
    for (int j = 0; j < 6; j++) begin
      cycle();
      if (mem_enable_o && j == 0) begin got_wr = mem_write_o; got_w = mem_data_o; end
      if (mem_ack_i) ack_at = j;
      if (d_ack_o) begin da_cnt++; dack_at = j; end
    end
    chk_b("wb_mem_write", got_wr, 1'b1);
    chk_w("wb_mem_data", got_w, pat_3c);
    chk_i("wb_d_ack_pulses", da_cnt, 1);
    chk_i("wb_ack_latency", dack_at - ack_at, 1);
    d_write_i = 1'b0;

    // Simultaneous I and D: D first, one IDLE cycle, then I
    mem_lat = 2; mem_data_i = pat_a5; d_addr_i = 32'h300; i_addr_i = 32'h400;
    i_req_i = 1'b1; d_req_i = 1'b1;
    en_v = '0; ia_v = '0; da_v = '0;
    for (int j = 0; j < 8; j++) begin
      cycle();
      en_v[j] = mem_enable_o; ia_v[j] = i_ack_o; da_v[j] = d_ack_o;
      if (j == 0) chk_a("collide_first_addr", mem_addr_o, 32'h300);
      if (j == 4) chk_a("collide_second_addr", mem_addr_o, 32'h400);
    end
    chk_i("collide_enable_seq", int'(en_v), 8'h33);
    chk_i("collide_d_ack_seq", int'(da_v), 8'h04);
    chk_i("collide_i_ack_seq", int'(ia_v), 8'h40);

    // Memory never acks: watchdog after 255 BUSY cycles
    mem_lat = 0; i_addr_i = 32'h500; i_req_i = 1'b1;
    cycle();
    for (int k = 2; k <= 260; k++) begin
      cycle();
      if (k == 255) chk_b("tmo_before_255", tmo_err_o, 1'b0);
      if (k == 256) chk_b("tmo_after_255", tmo_err_o, 1'b1);
    end
    chk_b("tmo_sticky", tmo_err_o, 1'b1);
    chk_b("tmo_still_enabled", mem_enable_o, 1'b1);

    // Asynchronous reset mid-BUSY, then held request re-granted
    @(posedge clk);
    #2 rst_i = 1'b1;
    #1;
    chk_b("async_rst_enable", mem_enable_o, 1'b0);
    chk_b("async_rst_tmo", tmo_err_o, 1'b0);
    chk_b("async_rst_i_ack", i_ack_o, 1'b0);
    cycle();
    rst_i = 1'b0;
    mem_lat = 3; mem_data_i = pat_3c;
    en_cnt = 0; ia_cnt = 0; got_w = '0;
    for (int j = 0; j < 7; j++) begin
      cycle();
      if (j == 0) chk_b("regrant_enable", mem_enable_o, 1'b1);
      if (mem_enable_o) en_cnt++;
      if (i_ack_o) begin ia_cnt++; got_w = rdata_o; end
    end
    chk_i("regrant_enable_cycles", en_cnt, 3);
    chk_i("regrant_i_ack_pulses", ia_cnt, 1);
    chk_w("regrant_rdata", got_w, pat_3c);

    // Spurious memory ack while idle
    spurious = 1'b1;
    ia_cnt = 0; da_cnt = 0; en_cnt = 0;
    for (int j = 0; j < 4; j++) begin
      cycle();
      if (i_ack_o) ia_cnt++;
      if (d_ack_o) da_cnt++;
      if (mem_enable_o) en_cnt++;
    end
    chk_i("spurious_acks", ia_cnt + da_cnt, 0);
    chk_i("spurious_enable", en_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
